svi_force_sequencer: RTL and testbench
======================================

// Module: svi_force_sequencer
// PURPOSE
//  Arbitrates and sequences tri-state override ("force to z") of an array of
//  N_LANE interface lanes shared by N_REQ requesters.
//  Round-robin grant; one requester owns the override at a time.
//  Its lane mask is applied for a programmed hold time, then released.
//  o_force_en drives the per-lane en of the lane-array forcing block.
// PARAMETERS
//  N_LANE  8  lanes in the interface array (bit i controls lane i)
//  N_REQ   4  requesters
//  HOLD_W  8  width of hold-time count
// PORTS
//  i_clk       in   1               clock; all state on posedge
//  i_arst_n    in   1               async reset, active low
//  i_req       in   N_REQ           level request per requester
//  i_mask      in   N_REQ*N_LANE    lane mask; requester r = [r*N_LANE +: N_LANE]
//  i_hold      in   N_REQ*HOLD_W    hold cycles; requester r = [r*HOLD_W +: HOLD_W]
//  o_gnt       out  N_REQ           one-hot grant, 0 when idle
//  o_force_en  out  N_LANE          1 = lane forced to z, 0 = released
//  o_busy      out  1               FSM not in IDLE
//  o_done      out  1               1-cycle pulse on completion/abort
// BEHAVIOUR
//  - Reset (async, i_arst_n=0): all outputs 0; FSM=IDLE; rr pointer=0.
//    A reset mid-sequence drops o_force_en in the same instant.
//  - FSM states: IDLE, SETUP, HOLD, RELEASE.
//  - IDLE: if |i_req, grant the first set bit at or after the pointer (wrapping).
//    Latch that requester's mask and hold; go to SETUP next cycle.
//    Pointer <= granted index + 1 (mod N_REQ).
//  - SETUP (1 cycle): o_force_en <= latched mask; counter <= max(hold,1)-1.
//    A latched mask of 0 skips directly to RELEASE.
//  - HOLD: decrement each cycle. At 0, go to RELEASE.
//    Total force_en high time = max(hold,1) cycles.
//  - RELEASE (1 cycle): o_force_en <= 0; o_done=1 this cycle; next state IDLE.
//  - o_gnt is asserted from SETUP through RELEASE inclusive and is 0 in IDLE.
//  - Grant-to-force latency: 1 cycle after the IDLE decision.
//  - Abort: if the granted i_req drops in SETUP or HOLD, go to RELEASE next cycle.
//  - Mask/hold inputs are sampled only at grant. Later changes are ignored until
//    the next grant.
//  - New requests during busy wait; no preemption.
//  - Simultaneous requests: strict round-robin from pointer.
//  - Counter is unsigned HOLD_W; no wrap (stops at 0).
// CONFIGURATION
//  SVI_FORCE_SEQ_GUARD_EN defined:
//    - Insert a GUARD state (1 cycle, all outputs 0 except o_busy=1) between
//      RELEASE and IDLE. This guarantees >=1 fully released cycle between owners.
//    - Back-to-back grant spacing is 1 cycle longer.
//  Not defined: RELEASE -> IDLE directly.
//    - The next SETUP can follow RELEASE after one IDLE cycle.
// TESTING
//  1. Reset with i_req=4'b0011 held
//     -> outputs all 0; after deassert, gnt=0001, force_en=mask0 one cycle later.
//  2. req0 only, mask0=8'hA5, hold0=3
//     -> force_en=8'hA5 for exactly 3 cycles; done pulses once; gnt back to 0.
//  3. req=4'b1111 held continuously
//     -> grants 0,1,2,3,0 in order; force_en never overlaps between owners.
//  4. hold=0 and mask=8'h01
//     -> force_en high 1 cycle.
//     mask=8'h00 -> force_en stays 0; done pulses; FSM returns to IDLE.
//  5. req1 granted, hold=10, req1 dropped at cycle 4 of HOLD
//     -> force_en=0 next cycle; done=1; next requester served.
//  6. i_arst_n pulsed low mid-HOLD
//     -> force_en=0 asynchronously; rr pointer=0.
//     With SVI_FORCE_SEQ_GUARD_EN: check 1 extra all-zero busy cycle per handover.

Source files
------------

// File: rtl/svi_force_sequencer.sv
// Round-robin owner of the lane-array "force to z" enables: one requester at a time,
// its lane mask held for a programmed time. SVI_FORCE_SEQ_GUARD_EN adds a guard cycle per handover.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no owner; grant first requester at/after rr pointer
// SETUP   | grant visible, lanes not yet forced
// HOLD    | lanes forced with latched mask, counter runs down to 0
// RELEASE | lanes released, done pulse, grant still visible
// GUARD   | fully released handover cycle (SVI_FORCE_SEQ_GUARD_EN only)
module svi_force_sequencer #(
  parameter int N_LANE = 8,
  parameter int N_REQ  = 4,
  parameter int HOLD_W = 8
) (
  input  logic                     i_clk,
  input  logic                     i_arst_n,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [N_REQ*N_LANE-1:0]  i_mask,
  input  logic [N_REQ*HOLD_W-1:0]  i_hold,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [N_LANE-1:0]        o_force_en,
  output logic                     o_busy,
  output logic                     o_done
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_HOLD    = 3'd2,
    S_RELEASE = 3'd3,
    S_GUARD   = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    ptr_q, own_q;
  logic [N_LANE-1:0]   mask_q;
  logic [HOLD_W-1:0]   cnt_q;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx, ptr_nxt;
  logic [N_LANE-1:0]   pick_mask;
  logic [HOLD_W-1:0]   pick_hold, cnt_load;
  logic                own_req;
  int                  cand;

  // Round-robin search starting at the pointer, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = (int'(ptr_q) + k) % N_REQ;
      if (!pick_found && i_req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IDX_W'(cand);
      end
    end
  end

  assign ptr_nxt   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
  assign pick_mask = i_mask[int'(pick_idx)*N_LANE +: N_LANE];
  assign pick_hold = i_hold[int'(pick_idx)*HOLD_W +: HOLD_W];
  // A hold of 0 behaves as 1; counter holds the remaining HOLD cycles minus one.
  assign cnt_load  = (pick_hold == '0) ? '0 : pick_hold - 1'b1;
  assign own_req   = i_req[own_q];

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      ptr_q  <= '0;
      own_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (state_q == S_IDLE && pick_found) begin
      ptr_q  <= ptr_nxt;
      own_q  <= pick_idx;
      mask_q <= pick_mask;
      cnt_q  <= cnt_load;
    end else if (state_q == S_HOLD && cnt_q != '0) begin
      cnt_q  <= cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (pick_found) state_d = S_SETUP;
      S_SETUP:   state_d = (!own_req || mask_q == '0) ? S_RELEASE : S_HOLD;
      S_HOLD:    if (!own_req || cnt_q == '0) state_d = S_RELEASE;
`ifdef SVI_FORCE_SEQ_GUARD_EN
      S_RELEASE: state_d = S_GUARD;
`else
      S_RELEASE: state_d = S_IDLE;
`endif
      S_GUARD:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // Outputs decode straight from state so an async reset clears them at once.
  always_comb begin
    o_gnt      = '0;
    o_force_en = '0;
    o_busy     = (state_q != S_IDLE);
    o_done     = (state_q == S_RELEASE);
    if (state_q == S_SETUP || state_q == S_HOLD || state_q == S_RELEASE) begin
      o_gnt[own_q] = 1'b1;
    end
    if (state_q == S_HOLD) begin
      o_force_en = mask_q;
    end
  end

endmodule

// File: tb/tb_svi_force_sequencer.sv
// Bench for svi_force_sequencer (default 8 lanes, 4 requesters, 8-bit hold).
// Follows SVI_FORCE_SEQ_GUARD_EN when defined for the build.
module tb_svi_force_sequencer;

`ifdef SVI_FORCE_SEQ_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic        i_clk;
  logic        i_arst_n;
  logic [3:0]  i_req;
  logic [31:0] i_mask;
  logic [31:0] i_hold;
  logic [3:0]  o_gnt;
  logic [7:0]  o_force_en;
  logic        o_busy;
  logic        o_done;

  int n_checks = 0;
  int n_fail   = 0;

  svi_force_sequencer #(.N_LANE(8), .N_REQ(4), .HOLD_W(8)) dut (
    .i_clk      (i_clk),
    .i_arst_n   (i_arst_n),
    .i_req      (i_req),
    .i_mask     (i_mask),
    .i_hold     (i_hold),
    .o_gnt      (o_gnt),
    .o_force_en (o_force_en),
    .o_busy     (o_busy),
    .o_done     (o_done)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Reference: current owner and its age in cycles since the grant became visible.
  int         m_owner, m_age, m_rel, m_ptr;
  bit         m_guard;
  logic [7:0] m_mask;

  int         gnt_log[$];
  logic [3:0] prev_gnt;
  int         seg_force_hi, seg_done;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_age   = 0;
    m_rel   = 0;
    m_ptr   = 0;
    m_guard = 1'b0;
    m_mask  = '0;
  endtask

  task automatic model_advance();
    int pick;
    int h;
    pick = -1;
    if (m_owner >= 0) begin
      if (m_age == m_rel) begin
        m_owner = -1;
        m_guard = GUARD;
      end else begin
        if (!i_req[m_owner]) m_rel = m_age + 1;
        m_age++;
      end
    end else if (m_guard) begin
      m_guard = 1'b0;
    end else if (i_req != 4'b0) begin
      for (int k = 0; k < 4; k++) begin
        if (pick < 0 && i_req[(m_ptr + k) % 4]) pick = (m_ptr + k) % 4;
      end
      m_owner = pick;
      m_age   = 0;
      m_mask  = i_mask[pick*8 +: 8];
      h       = int'(i_hold[pick*8 +: 8]);
      if (h == 0) h = 1;
      m_rel   = (m_mask == 8'h00) ? 1 : h + 1;
      m_ptr   = (pick + 1) % 4;
    end
  endtask

  task automatic step();
    logic [3:0] eg;
    logic [7:0] ef;
    logic       eb, ed;
    @(negedge i_clk);
    eg = '0; ef = '0; eb = 1'b0; ed = 1'b0;
    if (m_owner >= 0) begin
      eg = 4'(1 << m_owner);
      eb = 1'b1;
      if (m_age == m_rel) ed = 1'b1;
      else if (m_age >= 1) ef = m_mask;
    end else if (m_guard) begin
      eb = 1'b1;
    end
    check_val("gnt", 32'(o_gnt), 32'(eg));
    check_val("force_en", 32'(o_force_en), 32'(ef));
    check_val("busy", 32'(o_busy), 32'(eb));
    check_val("done", 32'(o_done), 32'(ed));
    if (o_force_en != 8'h00) seg_force_hi++;
    if (o_done) seg_done++;
    if (o_gnt != 4'b0 && prev_gnt == 4'b0) begin
      for (int r = 0; r < 4; r++) if (o_gnt[r]) gnt_log.push_back(r);
    end
    prev_gnt = o_gnt;
    model_advance();
    @(posedge i_clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic async_reset();
    #2 i_arst_n = 1'b0;
    #1;
    check_val("rst_force_en", 32'(o_force_en), 32'h0);
    check_val("rst_gnt", 32'(o_gnt), 32'h0);
    check_val("rst_busy", 32'(o_busy), 32'h0);
    check_val("rst_done", 32'(o_done), 32'h0);
    model_reset();
    @(posedge i_clk);
    #1 i_arst_n = 1'b1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_owner >= 0 || m_guard) && n < 300) begin
      step();
      n++;
    end
    check_val("idle_wait", 32'(o_busy), 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    prev_gnt     = '0;
    seg_force_hi = 0;
    seg_done     = 0;
    model_reset();

    // Reset with requests already pending
    i_arst_n = 1'b1;
    i_req    = 4'b0011;
    i_mask   = {8'h81, 8'h42, 8'h18, 8'h3C};
    i_hold   = {8'd2, 8'd2, 8'd2, 8'd2};
    #1 i_arst_n = 1'b0;
    #2;
    check_val("reset_gnt", 32'(o_gnt), 32'h0);
    check_val("reset_force_en", 32'(o_force_en), 32'h0);
    check_val("reset_busy", 32'(o_busy), 32'h0);
    check_val("reset_done", 32'(o_done), 32'h0);
    repeat (2) @(posedge i_clk);
    #1 i_arst_n = 1'b1;
    step();
    check_val("t1_gnt", 32'(o_gnt), 32'h1);
    step();
    check_val("t1_force_en", 32'(o_force_en), 32'h3C);
    i_req = 4'b0;
    wait_idle();

    // Single owner, hold 3
    i_mask[7:0] = 8'hA5;
    i_hold[7:0] = 8'd3;
    i_req = 4'b0001;
    seg_force_hi = 0; seg_done = 0;
    steps(5);
    i_req = 4'b0;
    steps(2);
    wait_idle();
    check_val("t2_force_cycles", 32'(seg_force_hi), 32'd3);
    check_val("t2_done_pulses", 32'(seg_done), 32'd1);

    // All requesting: strict round-robin from pointer 0
    async_reset();
    i_hold  = {8'd1, 8'd1, 8'd1, 8'd1};
    i_mask  = {8'hF0, 8'h0F, 8'hCC, 8'h33};
    gnt_log = {};
    i_req   = 4'b1111;
    steps(30);
    i_req = 4'b0;
    wait_idle();
    check_val("t3_grant_count", 32'(gnt_log.size() >= 5), 32'd1);
    for (int i = 0; i < 5 && i < gnt_log.size(); i++)
      check_val("t3_rr_order", 32'(gnt_log[i]), 32'(i % 4));

    // Hold 0 acts as 1; empty mask skips straight to release
    i_mask[23:16] = 8'h01;
    i_hold[23:16] = 8'd0;
    i_req = 4'b0100;
    seg_force_hi = 0; seg_done = 0;
    steps(3);
    i_req = 4'b0;
    steps(2);
    wait_idle();
    check_val("t4_hold0_force", 32'(seg_force_hi), 32'd1);
    i_mask[23:16] = 8'h00;
    i_hold[23:16] = 8'd5;
    i_req = 4'b0100;
    seg_force_hi = 0; seg_done = 0;
    steps(2);
    i_req = 4'b0;
    steps(2);
    wait_idle();
    check_val("t4_mask0_force", 32'(seg_force_hi), 32'd0);
    check_val("t4_mask0_done", 32'(seg_done), 32'd1);

    // Owner drops its request mid-hold, next requester takes over
    async_reset();
    i_mask  = {8'hC3, 8'h00, 8'h5A, 8'h00};
    i_hold  = {8'd2, 8'd0, 8'd10, 8'd0};
    gnt_log = {};
    i_req   = 4'b0010;
    step();
    i_req = 4'b1010;
    steps(4);
    i_req = 4'b1000;
    step();
    check_val("t5_abort_force", 32'(o_force_en), 32'h0);
    check_val("t5_abort_done", 32'(o_done), 32'h1);
    steps(6);
    i_req = 4'b0;
    wait_idle();
    check_val("t5_grants", 32'(gnt_log.size()), 32'd2);
    if (gnt_log.size() >= 2) check_val("t5_next_owner", 32'(gnt_log[1]), 32'd3);

    // Reset mid-hold, pointer returns to 0
    i_mask[7:0] = 8'hFF;
    i_hold[7:0] = 8'd10;
    i_req = 4'b0001;
    steps(4);
    check_val("t6_force_before", 32'(o_force_en), 32'hFF);
    async_reset();
    gnt_log = {};
    i_req = 4'b1111;
    steps(3);
    check_val("t6_ptr_reset", 32'(gnt_log.size() > 0 ? gnt_log[0] : -1), 32'd0);
    i_req = 4'b0;
    wait_idle();

    // Randomized traffic: inputs change freely, occasional async reset
    for (int c = 0; c < 4000; c++) begin
      for (int r = 0; r < 4; r++) begin
        if ($urandom_range(0, 7) == 0) i_req[r] = ~i_req[r];
        i_mask[r*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
        i_hold[r*8 +: 8] = 8'($urandom_range(0, 12));
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      else step();
    end
    i_req = 4'b0;
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
